// File: rtl/instr_fetch_unit_if.sv
// Purpose : bundles the instruction-memory read port and the core-facing
//           instruction port of the fetch unit into one interface.
// Ports   : memory side  mem_req/mem_addr (out), mem_ack/mem_rdata (in)
//           core side    instr/instr_pc/instr_valid/fifo_count (out),
//                        instr_take/redirect/redirect_pc/halt (in)
// The master modport is the fetch unit; the slave modport is the
// memory + core environment that answers it.
interface instr_fetch_unit_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Instruction-memory read handshake.
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_rdata;

  // Core-facing instruction port.
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic          instr_valid;
  logic          instr_take;

  // Control flow from the core.
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          halt;

  // Occupancy for debug.
  logic [CW-1:0] fifo_count;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata,
    output instr,
    output instr_pc,
    output instr_valid,
    input  instr_take,
    input  redirect,
    input  redirect_pc,
    input  halt,
    output fifo_count
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output instr_take,
    output redirect,
    output redirect_pc,
    output halt,
    input  fifo_count
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// Purpose     : fetch stage; keeps a fetch PC, reads words from instruction
//               memory over req/ack and queues {pc, word} in a prefetch FIFO.
// Latency     : an ack at edge N into an empty FIFO is visible on instr in
//               cycle N+1; mem_req is high straight out of reset.
// Backpressure: no request is issued while the FIFO is full, so an ack always
//               has a free slot; the core drains the head with instr_take.
// Ports       : clk, reset (async, active-high), bus (instr_fetch_unit_if.master)
//               carrying the memory read port, the core instruction port,
//               redirect/halt control and fifo_count.
module instr_fetch_unit #(
  parameter int          DEPTH    = 4,             // power of two, 2..16
  parameter logic [31:0] RESET_PC = 32'h0000_0000, // word aligned
  parameter int          PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    WAIT_SPACE = 2'd1,
    HALTED     = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  // Entry storage carries no reset: the outputs are gated by instr_valid,
  // so stale contents are never observed.
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];

  logic          push;
  logic          pop;
  logic [CW-1:0] count_next;
  logic          full_next;

  // Redirect wins over everything except reset: an ack or take in the same
  // cycle is dropped, so neither pushes nor pops.
  always_comb begin
    push       = (state == FETCH) && bus.mem_ack && !bus.redirect;
    pop        = bus.instr_take && (count != '0) && !bus.redirect;
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (!push && pop) begin
      count_next = count - CW'(1);
    end
    full_next  = (count_next == CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= bus.mem_rdata;
      pc_q[wr_ptr]   <= fetch_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (bus.redirect) begin
      state    <= FETCH;
      fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      count <= count_next;
      // Pointers are PW bits wide, so the power-of-two depth wraps for free.
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      case (state)
        FETCH: begin
          // Without an ack the address and request are held; halt only takes
          // effect once the outstanding request completes.
          if (bus.mem_ack) begin
            fetch_pc <= fetch_pc + 32'(PC_STEP);
            if (bus.halt) begin
              state <= HALTED;
            end else if (full_next) begin
              state <= WAIT_SPACE;
            end
          end
        end
        WAIT_SPACE: begin
          if (bus.halt) begin
            state <= HALTED;
          end else if (!full_next) begin
            state <= FETCH;
          end
        end
        HALTED: begin
          // Only a redirect (handled above) or reset restarts fetching.
          state <= HALTED;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  // mem_req is decoded from the state and masked by reset, so it drops
  // asynchronously with reset and rises as soon as reset is released.
  assign bus.mem_req     = (state == FETCH) && !reset;
  assign bus.mem_addr    = fetch_pc;
  assign bus.instr_valid = (count != '0);
  assign bus.instr       = bus.instr_valid ? data_q[rd_ptr] : 32'h0;
  assign bus.instr_pc    = bus.instr_valid ? pc_q[rd_ptr]   : 32'h0;
  assign bus.fifo_count  = count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a memory model answers requests,
// a scoreboard queue holds the {pc, word} entries the FIFO should contain.
module tb_instr_fetch_unit;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  ent_t sb[$];
  logic [31:0] exp_pc;

  instr_fetch_unit_if #(.DEPTH(DEPTH)) bus();

  instr_fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h29E0E756;
      32'h0000_0004: return 32'h35E4A163;
      32'h0000_0008: return 32'h39F221F0;
      32'h0000_000C: return 32'h3DE4BB34;
      default:       return a ^ 32'h5A3C_96E1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Post-edge view of the FIFO compared with the scoreboard.
  task automatic chk_fifo(input string tag);
    chk({tag, ":count"}, 32'(bus.fifo_count), 32'(sb.size()));
    chk({tag, ":valid"}, 32'(bus.instr_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk({tag, ":instr"},    bus.instr,    sb[0].data);
      chk({tag, ":instr_pc"}, bus.instr_pc, sb[0].pc);
    end
  endtask

  // One clock: drive inputs just after the falling edge, check, clock,
  // check #1 after the rising edge, return at the next falling edge.
  task automatic step(input bit ack, input bit take, input bit redir,
                      input logic [31:0] rpc, input string tag);
    ent_t e;
    bit   acc;
    acc             = ack && (bus.mem_req === 1'b1);
    bus.mem_ack     = acc;
    bus.mem_rdata   = acc ? word(bus.mem_addr) : 32'h0;
    bus.instr_take  = take;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    if (acc) begin
      chk({tag, ":mem_addr"}, bus.mem_addr, exp_pc);
    end
    if (take && !redir && sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ":take_instr"}, bus.instr, e.data);
      chk({tag, ":take_pc"}, bus.instr_pc, e.pc);
    end
    if (redir) begin
      sb.delete();
      exp_pc = {rpc[31:2], 2'b00};
    end else if (acc) begin
      e.pc   = exp_pc;
      e.data = word(exp_pc);
      sb.push_back(e);
      exp_pc = exp_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    chk_fifo(tag);
    @(negedge clk);
    bus.mem_ack    = 1'b0;
    bus.instr_take = 1'b0;
    bus.redirect   = 1'b0;
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    exp_pc          = 32'h0;
    reset           = 1'b1;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = 32'h0;
    bus.instr_take  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.halt        = 1'b0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst:mem_req",  32'(bus.mem_req), 32'd0);
    chk("rst:mem_addr", bus.mem_addr, 32'h0);
    chk("rst:count",    32'(bus.fifo_count), 32'd0);
    chk("rst:valid",    32'(bus.instr_valid), 32'd0);
    chk("rst:instr",    bus.instr, 32'h0);
    chk("rst:instr_pc", bus.instr_pc, 32'h0);
    reset = 1'b0;
    #1;
    chk("rel:mem_req",  32'(bus.mem_req), 32'd1);
    chk("rel:mem_addr", bus.mem_addr, 32'h0);
    @(negedge clk);

    // 1: fill to full with acks every cycle, no take.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, "fill");
    end
    chk("full:mem_req", 32'(bus.mem_req), 32'd0);
    chk("full:instr", bus.instr, 32'h29E0E756);
    chk("full:instr_pc", bus.instr_pc, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, "full_idle");
    chk("full_idle:mem_req", 32'(bus.mem_req), 32'd0);

    // 2: one take reopens fetching at 0x10.
    step(1'b0, 1'b1, 1'b0, 32'h0, "take1");
    chk("take1:mem_req", 32'(bus.mem_req), 32'd1);
    chk("take1:mem_addr", bus.mem_addr, 32'h10);
    chk("take1:instr", bus.instr, 32'h35E4A163);
    chk("take1:instr_pc", bus.instr_pc, 32'h4);

    // 3: ack delayed three cycles; address must hold.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, "wait");
      chk("wait:mem_req", 32'(bus.mem_req), 32'd1);
      chk("wait:mem_addr", bus.mem_addr, 32'h10);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0, "late_ack");
    chk("late_ack:count", 32'(bus.fifo_count), 32'd4);
    chk("late_ack:mem_req", 32'(bus.mem_req), 32'd0);

    // 4: drain to 2 entries, then redirect in the same cycle as an ack.
    step(1'b0, 1'b1, 1'b0, 32'h0, "drain_a");
    chk("drain_a:mem_addr", bus.mem_addr, 32'h14);
    step(1'b0, 1'b1, 1'b0, 32'h0, "drain_b");
    chk("drain_b:count", 32'(bus.fifo_count), 32'd2);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0103, "redir_ack");
    chk("redir_ack:count", 32'(bus.fifo_count), 32'd0);
    chk("redir_ack:mem_req", 32'(bus.mem_req), 32'd1);
    chk("redir_ack:mem_addr", bus.mem_addr, 32'h100);

    // 5: halt while a request is pending.
    step(1'b1, 1'b0, 1'b0, 32'h0, "pre_halt");
    bus.halt = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, "halt_wait");
      chk("halt_wait:mem_req", 32'(bus.mem_req), 32'd1);
      chk("halt_wait:mem_addr", bus.mem_addr, 32'h104);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0, "halt_ack");
    chk("halt_ack:mem_req", 32'(bus.mem_req), 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0, "halt_drain");
    step(1'b0, 1'b1, 1'b0, 32'h0, "halt_drain");
    chk("halted:valid", 32'(bus.instr_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, "halted_idle");
      chk("halted_idle:mem_req", 32'(bus.mem_req), 32'd0);
    end
    bus.halt = 1'b0;
    step(1'b0, 1'b0, 1'b1, 32'h0000_0040, "resume");
    chk("resume:mem_req", 32'(bus.mem_req), 32'd1);
    chk("resume:mem_addr", bus.mem_addr, 32'h40);
    step(1'b1, 1'b0, 1'b0, 32'h0, "resume_ack");

    // 6: PC wrap, then asynchronous reset mid-wait.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, "wrap_redir");
    step(1'b1, 1'b0, 1'b0, 32'h0, "wrap_ack0");
    step(1'b1, 1'b0, 1'b0, 32'h0, "wrap_ack1");
    chk("wrap:count", 32'(bus.fifo_count), 32'd2);
    chk("wrap:mem_addr", bus.mem_addr, 32'h4);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst:mem_req", 32'(bus.mem_req), 32'd0);
    chk("async_rst:count", 32'(bus.fifo_count), 32'd0);
    chk("async_rst:valid", 32'(bus.instr_valid), 32'd0);
    sb.delete();
    exp_pc = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel2:mem_req", 32'(bus.mem_req), 32'd1);
    chk("rel2:mem_addr", bus.mem_addr, 32'h0);
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 32'h0, "post_rst_ack");
    step(1'b0, 1'b1, 1'b0, 32'h0, "post_rst_take");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
